debounce_multi: RTL and testbench
=================================

// Module: debounce_multi
// PURPOSE
//  N-channel parametrised debouncer/edge detector for push-buttons and switches.
//  Per channel: a level is accepted only after it differs from the current debounced
//  level for STABLE_CYCLES consecutive samples. Outputs are the debounced level plus
//  one-cycle rise/fall pulses.
//  Sits between raw board inputs and MIPS control/IO logic; generalises the single-channel
//  press-pulse FSM.
// PARAMETERS
//  N_CH           4   number of independent channels
//  STABLE_CYCLES  3   consecutive differing samples needed to accept a change; must be >= 1
//  CNT_W          $clog2(STABLE_CYCLES+1)   derived counter width (localparam)
// PORTS
//  clk    in   1     single clock; all state updates on posedge
//  reset  in   1     synchronous, active-high reset
//  in     in   N_CH  raw inputs; bit i = channel i
//  level  out  N_CH  debounced level per channel
//  rise   out  N_CH  one-cycle pulse when level[i] goes 0->1
//  fall   out  N_CH  one-cycle pulse when level[i] goes 1->0
//  any_rise out 1    OR-reduction of rise (registered together with rise)
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high. On reset: level=0, rise=0,
//    fall=0, any_rise=0, all counters=0 (and sync flops=0 when enabled). Reset wins
//    over every other event.
//  - Per channel i, every posedge (not reset), with s = sampled in[i]:
//      s == level[i]              : cnt <= 0, no pulse (glitch/bounce cancels progress)
//      s != level[i], cnt < SC-1  : cnt <= cnt+1, no pulse
//      s != level[i], cnt == SC-1 : level[i] <= s, cnt <= 0,
//                                   rise[i] <= s, fall[i] <= ~s
//    Otherwise rise[i]/fall[i] <= 0 (pulses last exactly one cycle).
//  - Latency: input stable from sampling edge k -> level/pulse visible after edge
//    k+STABLE_CYCLES-1. STABLE_CYCLES=1: level tracks in with 1-cycle register delay.
//  - rise and fall are never both high on a channel; a channel pulses at most
//    once per STABLE_CYCLES cycles.
//  - Channels are fully independent; simultaneous events on several channels each
//    pulse in the same cycle. any_rise = |rise, so it is high in the same cycle.
//  - Counter never exceeds STABLE_CYCLES-1; no wrap-around is possible.
//  - Reset mid-count discards progress. An input held high through reset release
//    produces a fresh rise STABLE_CYCLES edges after release.
//  - No combinational path from in to any output.
// CONFIGURATION
//  DEBOUNCE_SYNC_EN defined: each in[i] passes through a 2-flop synchroniser before
//    the debounce logic. Flops reset to 0. Adds exactly 2 cycles to every latency above.
//  Not defined: in[i] is sampled directly by the debounce logic. The caller
//    guarantees the inputs are synchronous.
// TESTING  (N_CH=4, STABLE_CYCLES=3, macro off unless stated)
//  1 reset=1 for 2 cycles, in=4'hF -> level=0, rise=0, fall=0, any_rise=0 throughout;
//    after release, rise=4'hF for one cycle on the 3rd edge, then level=4'hF.
//  2 in[0] 0->1 held -> rise[0]=1 for exactly one cycle on the 3rd sampling edge;
//    level[0]=1 from then on; in[0] 1->0 held -> fall[0] one cycle after 3 edges.
//  3 Bounce on in[1]: 1,1,0,1,1,0 -> level[1] stays 0, no pulses;
//    then 1,1,1 -> rise[1] on the 3rd.
//  4 in[2] and in[3] rise on the same edge -> rise=4'b1100 in one cycle, any_rise=1 that cycle only.
//  5 in[0] high for 2 edges, then reset=1 -> cnt cleared; after release, in[0] still high
//    -> rise[0] only after 3 further edges.
//  6 DEBOUNCE_SYNC_EN defined, repeat test 2 -> rise[0] appears 2 cycles later (5th edge),
//    same one-cycle width.

Source files
------------

// File: rtl/debounce_multi.sv
// debounce_multi: N-channel debouncer producing a debounced level and one-cycle rise/fall pulses.
// Define DEBOUNCE_SYNC_EN to put a 2-flop synchroniser in front of every channel.
module debounce_multi #(
    parameter int N_CH          = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] in,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic            any_rise
);
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [N_CH-1:0]  s;
    logic [N_CH-1:0]  done;
    logic [CNT_W-1:0] cnt     [N_CH];
    logic [CNT_W-1:0] cnt_nxt [N_CH];

`ifdef DEBOUNCE_SYNC_EN
    logic [N_CH-1:0] meta, sync;
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= in;
            sync <= meta;
        end
    end
    assign s = sync;
`else
    assign s = in;
`endif

    // Matching samples cancel progress; the SC-th consecutive differing sample is accepted.
    always_comb begin
        done = '0;
        for (int c = 0; c < N_CH; c++) begin
            done[c]    = (s[c] != level[c]) && (cnt[c] == LAST);
            cnt_nxt[c] = (s[c] != level[c] && !done[c]) ? cnt[c] + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level    <= '0;
            rise     <= '0;
            fall     <= '0;
            any_rise <= 1'b0;
            cnt      <= '{default: '0};
        end else begin
            level    <= level ^ done;
            rise     <= done & s;
            fall     <= done & ~s;
            any_rise <= |(done & s);
            cnt      <= cnt_nxt;
        end
    end
endmodule

// File: tb/tb_debounce_multi.sv
// tb_debounce_multi: directed and random stimulus checked against a sample-history model.
module tb_debounce_multi;
    localparam int N  = 4;
    localparam int SC = 3;
`ifdef DEBOUNCE_SYNC_EN
    localparam int LAT = SC + 2;
`else
    localparam int LAT = SC;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] in = '0;
    logic [N-1:0] level, rise, fall;
    logic         any_rise;

    debounce_multi #(.N_CH(N), .STABLE_CYCLES(SC)) dut (
        .clk(clk), .reset(reset), .in(in),
        .level(level), .rise(rise), .fall(fall), .any_rise(any_rise)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: a change is accepted when the last SC samples seen since the level last
    // changed (or since reset) all disagree with the current level.
    logic [N-1:0] m_level = '0, m_rise = '0, m_fall = '0;
    logic [N-1:0] sp1 = '0, sp2 = '0;
    bit           hist [N][$];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic [N-1:0] v);
        logic [N-1:0] s;
        int           n;
        bit           ok;
        if (r) begin
            m_level = '0; m_rise = '0; m_fall = '0; sp1 = '0; sp2 = '0;
            for (int c = 0; c < N; c++) hist[c].delete();
            return;
        end
`ifdef DEBOUNCE_SYNC_EN
        s = sp2; sp2 = sp1; sp1 = v;
`else
        s = v;
`endif
        m_rise = '0;
        m_fall = '0;
        for (int c = 0; c < N; c++) begin
            hist[c].push_back(s[c]);
            if (hist[c].size() > SC) void'(hist[c].pop_front());
            n  = hist[c].size();
            ok = (n >= SC);
            for (int k = 0; k < SC && ok; k++)
                if (hist[c][n-1-k] == m_level[c]) ok = 0;
            if (ok) begin
                m_level[c] = s[c];
                m_rise[c]  = s[c];
                m_fall[c]  = ~s[c];
                hist[c].delete();
            end
        end
    endtask

    task automatic step(input logic r, input logic [N-1:0] v);
        reset = r;
        in    = v;
        @(posedge clk);
        model_edge(r, v);
        #1;
        chk("level", 8'(level), 8'(m_level));
        chk("rise", 8'(rise), 8'(m_rise));
        chk("fall", 8'(fall), 8'(m_fall));
        chk("any_rise", 8'(any_rise), 8'(|m_rise));
        chk("rise_and_fall", 8'(rise & fall), 8'h0);
    endtask

    task automatic hold(input logic [N-1:0] v, input int n);
        for (int i = 0; i < n; i++) step(1'b0, v);
    endtask

    initial begin
        logic [N-1:0] v;
        // Reset held with all inputs high: everything stays cleared.
        step(1'b1, 4'hF);
        chk("reset_level", 8'(level), 8'h0);
        step(1'b1, 4'hF);
        chk("reset_rise", 8'(rise), 8'h0);
        chk("reset_any", 8'(any_rise), 8'h0);
        for (int i = 0; i < LAT - 1; i++) begin
            step(1'b0, 4'hF);
            chk("release_early_rise", 8'(rise), 8'h0);
        end
        step(1'b0, 4'hF);
        chk("release_rise", 8'(rise), 8'hF);
        chk("release_any", 8'(any_rise), 8'h1);
        step(1'b0, 4'hF);
        chk("release_pulse_end", 8'(rise), 8'h0);
        chk("release_level", 8'(level), 8'hF);
        // Return to 0 on all channels, then single-channel press/release.
        hold(4'h0, LAT + 1);
        chk("all_low", 8'(level), 8'h0);
        for (int i = 0; i < LAT - 1; i++) step(1'b0, 4'h1);
        step(1'b0, 4'h1);
        chk("ch0_rise", 8'(rise), 8'h1);
        step(1'b0, 4'h1);
        chk("ch0_rise_width", 8'(rise), 8'h0);
        chk("ch0_level", 8'(level), 8'h1);
        hold(4'h0, LAT - 1);
        step(1'b0, 4'h0);
        chk("ch0_fall", 8'(fall), 8'h1);
        hold(4'h0, 2);
        // Bounce on channel 1 never reaches SC consecutive samples.
        v = 4'h0;
        foreach (v[i]) v[i] = 1'b0;
        step(1'b0, 4'h2); step(1'b0, 4'h2); step(1'b0, 4'h0);
        step(1'b0, 4'h2); step(1'b0, 4'h2); step(1'b0, 4'h0);
        hold(4'h0, 3);
        chk("bounce_level", 8'(level), 8'h0);
        hold(4'h2, LAT + 1);
        chk("bounce_settled", 8'(level), 8'h2);
        hold(4'h0, LAT + 1);
        // Two channels rising together.
        hold(4'hC, LAT - 1);
        step(1'b0, 4'hC);
        chk("dual_rise", 8'(rise), 8'hC);
        chk("dual_any", 8'(any_rise), 8'h1);
        step(1'b0, 4'hC);
        chk("dual_any_end", 8'(any_rise), 8'h0);
        hold(4'h0, LAT + 1);
        // Reset mid-count discards progress.
        hold(4'h1, 2);
        step(1'b1, 4'h1);
        for (int i = 0; i < LAT - 1; i++) begin
            step(1'b0, 4'h1);
            chk("midreset_early", 8'(rise), 8'h0);
        end
        step(1'b0, 4'h1);
        chk("midreset_rise", 8'(rise), 8'h1);
        // Random bouncy inputs with occasional resets.
        v = '0;
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < N; c++)
                if ($urandom_range(0, 3) == 0) v[c] = ~v[c];
            step(($urandom_range(0, 60) == 0), v);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
